// File: rtl/source_flow_ctrl_gate.sv
// Packet-granular window gate for a CHDR source: new packets start only while
// fewer than window_size packets are unacknowledged; returning FC packets carry the ack seqnum.
module source_flow_ctrl_gate #(
    parameter logic [7:0] SR_FLOW_CTRL_WINDOW_SIZE = 8'd0,
    parameter logic [7:0] SR_FLOW_CTRL_WINDOW_EN   = 8'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    input  logic [63:0] fc_tdata,
    input  logic        fc_tlast,
    input  logic        fc_tvalid,
    output logic        fc_tready,
    output logic        window_full,
    output logic [31:0] in_flight
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    localparam logic [1:0] FC_HDR     = 2'd0;
    localparam logic [1:0] FC_TIME    = 2'd1;
    localparam logic [1:0] FC_PAYLOAD = 2'd2;
    localparam logic [1:0] FC_DUMP    = 2'd3;

    logic [31:0] r_window_size;
    logic        r_window_en;
    logic [31:0] r_sent_count;
    logic [31:0] r_ack_count;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_fc_state;
    logic [1:0]  w_fc_state_nxt;

    logic        w_below_window;
    logic        w_go;
    logic        w_xfer;
    logic        w_ack_load;
    logic [31:0] w_in_flight;

    // Settings survive clear; only reset returns them to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window_size <= 32'd0;
            r_window_en   <= 1'b0;
        end else if (set_stb) begin
            if (set_addr == SR_FLOW_CTRL_WINDOW_SIZE) r_window_size <= set_data;
            if (set_addr == SR_FLOW_CTRL_WINDOW_EN)   r_window_en   <= set_data[0];
        end
    end

    assign w_in_flight    = r_sent_count - r_ack_count;
    assign w_below_window = (w_in_flight < r_window_size);
    // Once a packet has started it runs to completion regardless of the window.
    assign w_go           = (r_state == ST_PKT) | ~r_window_en | w_below_window;

    assign o_tdata     = i_tdata;
    assign o_tlast     = i_tlast;
    assign o_tvalid    = i_tvalid & w_go;
    assign i_tready    = o_tready & w_go;
    assign w_xfer      = o_tvalid & o_tready;
    assign in_flight   = w_in_flight;
    assign window_full = r_window_en & ~w_below_window;
    assign fc_tready   = 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = i_tlast ? ST_IDLE : ST_PKT;
        end
    end

    always_comb begin
        w_fc_state_nxt = r_fc_state;
        if (fc_tvalid) begin
            case (r_fc_state)
                FC_HDR: begin
                    if (fc_tlast)          w_fc_state_nxt = FC_HDR;
                    else if (fc_tdata[61]) w_fc_state_nxt = FC_TIME;
                    else                   w_fc_state_nxt = FC_PAYLOAD;
                end
                FC_TIME:    w_fc_state_nxt = fc_tlast ? FC_HDR : FC_PAYLOAD;
                FC_PAYLOAD: w_fc_state_nxt = fc_tlast ? FC_HDR : FC_DUMP;
                FC_DUMP:    w_fc_state_nxt = fc_tlast ? FC_HDR : FC_DUMP;
                default:    w_fc_state_nxt = FC_HDR;
            endcase
        end
    end

    assign w_ack_load = fc_tvalid & (r_fc_state == FC_PAYLOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fc_state   <= FC_HDR;
            r_sent_count <= 32'd0;
            r_ack_count  <= 32'd0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_fc_state   <= FC_HDR;
            r_sent_count <= 32'd0;
            r_ack_count  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fc_state <= w_fc_state_nxt;
            if (w_xfer && i_tlast) r_sent_count <= r_sent_count + 32'd1;
            // Ack is taken verbatim; a stale seqnum may legitimately raise in_flight.
            if (w_ack_load)        r_ack_count  <= fc_tdata[31:0] + 32'd1;
        end
    end

endmodule
